// File: rtl/reg_file_if.sv
// Operand-read / write-back bus of the MIPS register file.
// master: pipeline side (drives write-back and read addresses); slave: register file.
interface reg_file_if #(
    parameter int ADDR_W     = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  write_en;
    logic [ADDR_W-1:0]     write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en_1;
    logic [ADDR_W-1:0]     read_addr_1;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic                  read_en_2;
    logic [ADDR_W-1:0]     read_addr_2;
    logic [DATA_WIDTH-1:0] read_data_2;

    modport master (
        output write_en, write_addr, write_data,
        output read_en_1, read_addr_1,
        output read_en_2, read_addr_2,
        input  read_data_1, read_data_2
    );

    modport slave (
        input  write_en, write_addr, write_data,
        input  read_en_1, read_addr_1,
        input  read_en_2, read_addr_2,
        output read_data_1, read_data_2
    );
endinterface

// File: rtl/reg_file.sv
// MIPS GPR file: REG_NUM x DATA_WIDTH, two combinational reads, one clocked write.
// Ports: clk, rst (async, active-low), rf (reg_file_if.slave: write port + two read ports).
// Optional macro REG_WRITE_BYPASS_EN forwards a same-cycle write-back to a matching read.
module reg_file #(
    parameter int REG_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 0
) (
    input  logic      clk,
    input  logic      rst,
    reg_file_if.slave rf
);
    localparam int ADDR_W = $clog2(REG_NUM);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  wr_ok;

    // Writes to the hardwired-zero register are dropped here, so it never leaves 0.
    assign wr_ok = rf.write_en && (rf.write_addr != ZERO_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rf.write_addr] <= rf.write_data;
        end
    end

    // Outputs are forced to 0 while in reset: the array is already clear,
    // but the bypass path would otherwise leak write_data during reset.
    always_comb begin
        rf.read_data_1 = '0;
        if (rst && rf.read_en_1 && (rf.read_addr_1 != ZERO_ADDR)) begin
`ifdef REG_WRITE_BYPASS_EN
            if (wr_ok && (rf.write_addr == rf.read_addr_1)) begin
                rf.read_data_1 = rf.write_data;
            end else begin
                rf.read_data_1 = regs[rf.read_addr_1];
            end
`else
            rf.read_data_1 = regs[rf.read_addr_1];
`endif
        end
    end

    always_comb begin
        rf.read_data_2 = '0;
        if (rst && rf.read_en_2 && (rf.read_addr_2 != ZERO_ADDR)) begin
`ifdef REG_WRITE_BYPASS_EN
            if (wr_ok && (rf.write_addr == rf.read_addr_2)) begin
                rf.read_data_2 = rf.write_data;
            end else begin
                rf.read_data_2 = regs[rf.read_addr_2];
            end
`else
            rf.read_data_2 = regs[rf.read_addr_2];
`endif
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array model + per-cycle compare + literal checks.
// Build with or without REG_WRITE_BYPASS_EN; expectations follow the macro.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   running = 1'b0;

    logic [31:0] m [32];

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural model: plain array, cleared by reset, $0 writes ignored.
    initial foreach (m[i]) m[i] = 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m[i]) m[i] = 32'h0;
        end else if (bus.write_en && bus.write_addr != 5'd0) begin
            m[bus.write_addr] = bus.write_data;
        end
    end

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
        if (!rst || !en || a == 5'd0) return 32'h0;
`ifdef REG_WRITE_BYPASS_EN
        if (bus.write_en && bus.write_addr == a) return bus.write_data;
`endif
        return m[a];
    endfunction

    always @(negedge clk) begin
        if (running) begin
            check("cmp_port1", bus.read_data_1, exp_rd(bus.read_en_1, bus.read_addr_1));
            check("cmp_port2", bus.read_data_2, exp_rd(bus.read_en_2, bus.read_addr_2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.write_en   = en;
        bus.write_addr = a;
        bus.write_data = d;
    endtask

    task automatic drive_rd(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
        bus.read_en_1   = e1;
        bus.read_addr_1 = a1;
        bus.read_en_2   = e2;
        bus.read_addr_2 = a2;
    endtask

    initial begin
        logic [31:0] pat;
        // Reset with a write pending and bypass-matching address: all lost.
        rst = 1'b0;
        drive_wr(1'b1, 5'd5, 32'h1234_5678);
        drive_rd(1'b1, 5'd5, 1'b1, 5'd6);
        running = 1'b1;
        step(); step();
        #2;
        check("rst_rd1", bus.read_data_1, 32'h0);
        check("rst_rd2", bus.read_data_2, 32'h0);

        step();
        rst = 1'b1;
        drive_wr(1'b0, 5'd5, 32'h0);
        step();
        #2;
        check("post_rst_rd1", bus.read_data_1, 32'h0);
        check("post_rst_rd2", bus.read_data_2, 32'h0);

        // Basic write/read.
        drive_wr(1'b1, 5'd8, 32'hDEAD_BEEF);
        step();
        drive_wr(1'b0, 5'd0, 32'h0);
        drive_rd(1'b1, 5'd8, 1'b1, 5'd6);
        #2;
        check("wr8_rd1", bus.read_data_1, 32'hDEAD_BEEF);
        drive_rd(1'b0, 5'd8, 1'b1, 5'd8);
        #1;
        check("wr8_en0", bus.read_data_1, 32'h0);
        check("wr8_rd2", bus.read_data_2, 32'hDEAD_BEEF);

        // $0 protection.
        step();
        drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        drive_wr(1'b0, 5'd0, 32'h0);
        drive_rd(1'b1, 5'd0, 1'b1, 5'd0);
        #2;
        check("zero_rd1", bus.read_data_1, 32'h0);
        check("zero_rd2", bus.read_data_2, 32'h0);

        // Same-cycle hazard on port 2, plus unrelated read on port 1.
        step();
        drive_wr(1'b1, 5'd3, 32'h11);
        step();
        drive_wr(1'b1, 5'd3, 32'h22);
        drive_rd(1'b1, 5'd8, 1'b1, 5'd3);
        #2;
`ifdef REG_WRITE_BYPASS_EN
        check("hazard_same", bus.read_data_2, 32'h22);
`else
        check("hazard_same", bus.read_data_2, 32'h11);
`endif
        check("hazard_other", bus.read_data_1, 32'hDEAD_BEEF);
        step();
        drive_wr(1'b0, 5'd0, 32'h0);
        #2;
        check("hazard_after", bus.read_data_2, 32'h22);

        // Pattern fill 1..30, then read back pairs.
        for (int i = 1; i < 31; i++) begin
            step();
            pat = (32'h0101_0101 * i) ^ 32'hC3;
            drive_wr(1'b1, 5'(i), pat);
            drive_rd(1'b1, 5'(i), 1'b1, 5'(31 - i));
        end
        step();
        drive_wr(1'b0, 5'd0, 32'h0);
        for (int i = 1; i < 31; i++) begin
            drive_rd(1'b1, 5'(i), 1'b1, 5'(31 - i));
            step();
        end

        // Dual port on 31.
        drive_wr(1'b1, 5'd31, 32'hA5A5_A5A5);
        step();
        drive_wr(1'b0, 5'd0, 32'h0);
        drive_rd(1'b1, 5'd31, 1'b1, 5'd31);
        #2;
        check("dual_rd1", bus.read_data_1, 32'hA5A5_A5A5);
        check("dual_rd2", bus.read_data_2, 32'hA5A5_A5A5);

        // Async reset between edges.
        step();
        rst = 1'b0;
        #1;
        check("async_rd1", bus.read_data_1, 32'h0);
        check("async_rd2", bus.read_data_2, 32'h0);
        #4;
        rst = 1'b1;
        step();
        #2;
        check("after_rel_31", bus.read_data_1, 32'h0);
        check("after_rel_8", m[8], 32'h0);
        step();
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
